// File: rtl/exec_regalu_core_if.sv
// rtl/exec_regalu_core_if.sv - bus bundle between decode/write-back and the execute core
//
// Purpose: groups the register-file, ALU-control and ALU signals of
//          exec_regalu_core so the core takes one bus port beside clk/rst_n.
// Signals:
//   reg_write, reg_write_dest, reg_write_data  GPR write port
//   reg_read_addr1, reg_read_addr2             GPR read addresses
//   reg_read_data1, reg_read_data2             GPR read data (port 2 is also store data)
//   aluop, opcode                              ALU operation class and instruction opcode
//   alu_src, imm                               operand B select and immediate field
//   alu_ctrl, alu_out, zero                    decoded ALU select, result, zero flag
// Modports:
//   master - decode/write-back side (drives addresses, controls, write data)
//   slave  - execute core side
interface exec_regalu_core_if #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 3,
   parameter int IMM_W  = 6
);
   logic              reg_write;
   logic [REG_AW-1:0] reg_write_dest;
   logic [DATA_W-1:0] reg_write_data;
   logic [REG_AW-1:0] reg_read_addr1;
   logic [REG_AW-1:0] reg_read_addr2;
   logic [DATA_W-1:0] reg_read_data1;
   logic [DATA_W-1:0] reg_read_data2;
   logic [1:0]        aluop;
   logic [3:0]        opcode;
   logic              alu_src;
   logic [IMM_W-1:0]  imm;
   logic [2:0]        alu_ctrl;
   logic [DATA_W-1:0] alu_out;
   logic              zero;

   modport master (
      output reg_write, reg_write_dest, reg_write_data,
      output reg_read_addr1, reg_read_addr2,
      output aluop, opcode, alu_src, imm,
      input  reg_read_data1, reg_read_data2,
      input  alu_ctrl, alu_out, zero
   );

   modport slave (
      input  reg_write, reg_write_dest, reg_write_data,
      input  reg_read_addr1, reg_read_addr2,
      input  aluop, opcode, alu_src, imm,
      output reg_read_data1, reg_read_data2,
      output alu_ctrl, alu_out, zero
   );
endinterface

// File: rtl/exec_regalu_core.sv
// rtl/exec_regalu_core.sv - execute stage: 8-entry GPR file, ALU-control decoder, 32-bit ALU
//
// Purpose: register file with two combinational read ports and one synchronous
//          write port, feeding an ALU whose function is decoded from aluop and
//          the instruction opcode. The ALU path is purely combinational.
// Ports:
//   clk    - system clock, state updates on rising edge
//   rst_n  - asynchronous active-low reset, clears every GPR
//   bus    - exec_regalu_core_if.slave (write port, read ports, ALU controls/results)
// Build option:
//   GPR_R0_ZERO_EN - when defined, GPR[0] reads as 0 and writes to it are dropped;
//                    when undefined (default), GPR[0] is an ordinary register.
module exec_regalu_core #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 3,
   parameter int IMM_W  = 6
) (
   input  logic                   clk,
   input  logic                   rst_n,
   exec_regalu_core_if.slave      bus
);

   localparam int NREG = 1 << REG_AW;
   localparam int SH_W = $clog2(DATA_W);

   typedef enum logic [2:0] {
      SEL_ADD = 3'b000,
      SEL_SUB = 3'b001,
      SEL_INV = 3'b010,
      SEL_SLL = 3'b011,
      SEL_SRL = 3'b100,
      SEL_AND = 3'b101,
      SEL_OR  = 3'b110,
      SEL_SLT = 3'b111
   } alu_sel_e;

   logic [DATA_W-1:0] regs [NREG];
   logic              wr_armed;
   logic              wr_en;
   logic [DATA_W-1:0] op_a;
   logic [DATA_W-1:0] op_b;
   logic [DATA_W-1:0] imm_ext;
   logic [SH_W-1:0]   shamt;
   alu_sel_e          sel;
   logic [DATA_W-1:0] result;

   // ------------------------------------------------------------------
   // Write arming: stays low through reset and for the edge on which reset
   // is released, so a release coincident with a clock edge cannot write.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_armed <= 1'b0;
      end else begin
         wr_armed <= 1'b1;
      end
   end

`ifdef GPR_R0_ZERO_EN
   assign wr_en = bus.reg_write && wr_armed && (bus.reg_write_dest != '0);
`else
   assign wr_en = bus.reg_write && wr_armed;
`endif

   // ------------------------------------------------------------------
   // Register file
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) begin
            regs[i] <= '0;
         end
      end else if (wr_en) begin
         regs[bus.reg_write_dest] <= bus.reg_write_data;
      end
   end

   // Reads see the stored value only; a write at edge N appears after edge N.
`ifdef GPR_R0_ZERO_EN
   assign bus.reg_read_data1 = (bus.reg_read_addr1 == '0) ? '0 : regs[bus.reg_read_addr1];
   assign bus.reg_read_data2 = (bus.reg_read_addr2 == '0) ? '0 : regs[bus.reg_read_addr2];
`else
   assign bus.reg_read_data1 = regs[bus.reg_read_addr1];
   assign bus.reg_read_data2 = regs[bus.reg_read_addr2];
`endif

   // ------------------------------------------------------------------
   // ALU control decode
   // ------------------------------------------------------------------
   always_comb begin
      sel = SEL_ADD;
      unique case (bus.aluop)
         2'b10: sel = SEL_ADD;            // load/store address
         2'b01: sel = SEL_SUB;            // branch compare
         2'b00: begin
            case (bus.opcode)
               4'b0010: sel = SEL_ADD;
               4'b0011: sel = SEL_SUB;
               4'b0100: sel = SEL_INV;
               4'b0101: sel = SEL_SLL;
               4'b0110: sel = SEL_SRL;
               4'b0111: sel = SEL_AND;
               4'b1000: sel = SEL_OR;
               4'b1001: sel = SEL_SLT;
               default: sel = SEL_ADD;
            endcase
         end
         default: sel = SEL_ADD;          // aluop 2'b11
      endcase
   end

   assign bus.alu_ctrl = sel;

   // ------------------------------------------------------------------
   // Operands
   // ------------------------------------------------------------------
   assign imm_ext = {{(DATA_W-IMM_W){bus.imm[IMM_W-1]}}, bus.imm};
   assign op_a    = bus.reg_read_data1;
   assign op_b    = bus.alu_src ? imm_ext : bus.reg_read_data2;
   // Only the low log2(DATA_W) bits of B form the shift amount.
   assign shamt   = op_b[SH_W-1:0];

   // ------------------------------------------------------------------
   // ALU
   // ------------------------------------------------------------------
   always_comb begin
      result = '0;
      unique case (sel)
         SEL_ADD: result = op_a + op_b;
         SEL_SUB: result = op_a - op_b;
         SEL_INV: result = ~op_a;
         SEL_SLL: result = op_a << shamt;
         SEL_SRL: result = op_a >> shamt;
         SEL_AND: result = op_a & op_b;
         SEL_OR:  result = op_a | op_b;
         SEL_SLT: result = {{(DATA_W-1){1'b0}}, (op_a < op_b)};
         default: result = '0;
      endcase
   end

   assign bus.alu_out = result;
   assign bus.zero    = (result == '0);

endmodule

// File: tb/tb_exec_regalu_core.sv
// tb/tb_exec_regalu_core.sv - scoreboard bench for exec_regalu_core
module tb_exec_regalu_core;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   exec_regalu_core_if #(.DATA_W(32), .REG_AW(3), .IMM_W(6)) bus ();

   exec_regalu_core #(.DATA_W(32), .REG_AW(3), .IMM_W(6)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      string       name;
      logic [31:0] rd1;
      logic [31:0] rd2;
      logic [31:0] out;
      logic        zero;
      logic [2:0]  ctrl;
      logic [4:0]  mask;   // 0 rd1, 1 rd2, 2 out, 3 zero, 4 ctrl
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   failures = 0;
   logic chk_req = 1'b0;

   task automatic cmp(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s.%s actual=0x%08h required=0x%08h", nm, fld, act, exp);
      end
   endtask

   // Monitor: pops one expectation per presented sample.
   always @(posedge chk_req) begin
      exp_t e;
      if (sb.size() == 0) begin
         checks++;
         failures++;
         $display("FAIL scoreboard_empty actual=0 required=1");
      end else begin
         e = sb.pop_front();
         if (e.mask[0]) cmp(e.name, "rd1",  bus.reg_read_data1, e.rd1);
         if (e.mask[1]) cmp(e.name, "rd2",  bus.reg_read_data2, e.rd2);
         if (e.mask[2]) cmp(e.name, "out",  bus.alu_out, e.out);
         if (e.mask[3]) cmp(e.name, "zero", {31'b0, bus.zero}, {31'b0, e.zero});
         if (e.mask[4]) cmp(e.name, "ctrl", {29'b0, bus.alu_ctrl}, {29'b0, e.ctrl});
      end
   end

   task automatic push(input string nm, input logic [31:0] rd1, input logic [31:0] rd2,
                       input logic [31:0] out, input logic z, input logic [2:0] ctrl,
                       input logic [4:0] mask);
      exp_t e;
      e.name = nm; e.rd1 = rd1; e.rd2 = rd2; e.out = out;
      e.zero = z; e.ctrl = ctrl; e.mask = mask;
      #1;
      sb.push_back(e);
      chk_req = 1'b1;
      #1;
      chk_req = 1'b0;
   endtask

   task automatic exp_rd(input string nm, input logic [31:0] rd1, input logic [31:0] rd2);
      push(nm, rd1, rd2, 32'h0, 1'b0, 3'b000, 5'b00011);
   endtask

   task automatic exp_alu(input string nm, input logic [31:0] out, input logic z, input logic [2:0] ctrl);
      push(nm, 32'h0, 32'h0, out, z, ctrl, 5'b11100);
   endtask

   task automatic write_reg(input logic [2:0] addr, input logic [31:0] data);
      @(negedge clk);
      bus.reg_write      = 1'b1;
      bus.reg_write_dest = addr;
      bus.reg_write_data = data;
      @(posedge clk);
      #1;
      bus.reg_write      = 1'b0;
   endtask

   task automatic set_op(input logic [2:0] a1, input logic [2:0] a2, input logic [1:0] op_class,
                         input logic [3:0] opc, input logic src, input logic [5:0] immv);
      @(negedge clk);
      bus.reg_read_addr1 = a1;
      bus.reg_read_addr2 = a2;
      bus.aluop          = op_class;
      bus.opcode         = opc;
      bus.alu_src        = src;
      bus.imm            = immv;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.reg_write = 1'b0; bus.reg_write_dest = '0; bus.reg_write_data = '0;
      bus.reg_read_addr1 = '0; bus.reg_read_addr2 = '0;
      bus.aluop = 2'b00; bus.opcode = 4'b0000; bus.alu_src = 1'b0; bus.imm = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);

      // Reset state
      set_op(3'd0, 3'd5, 2'b00, 4'b0010, 1'b0, 6'd0);
      exp_rd("reset_rd", 32'h0, 32'h0);
      exp_alu("reset_add", 32'h0, 1'b1, 3'b000);

      // Write/read and R-type ADD/SUB
      write_reg(3'd1, 32'd5);
      write_reg(3'd2, 32'd7);
      set_op(3'd1, 3'd2, 2'b00, 4'b0010, 1'b0, 6'd0);
      exp_rd("wr_rd", 32'd5, 32'd7);
      exp_alu("add_5_7", 32'd12, 1'b0, 3'b000);
      set_op(3'd2, 3'd2, 2'b00, 4'b0011, 1'b0, 6'd0);
      exp_rd("same_reg", 32'd7, 32'd7);
      exp_alu("sub_7_7", 32'h0, 1'b1, 3'b001);

      // Decode
      set_op(3'd1, 3'd2, 2'b10, 4'b0111, 1'b0, 6'd0);
      exp_alu("dec_ldst", 32'd12, 1'b0, 3'b000);
      set_op(3'd1, 3'd2, 2'b01, 4'b0111, 1'b0, 6'd0);
      exp_alu("dec_branch", 32'hFFFF_FFFE, 1'b0, 3'b001);
      set_op(3'd1, 3'd2, 2'b00, 4'b1001, 1'b0, 6'd0);
      exp_alu("dec_slt", 32'd1, 1'b0, 3'b111);
      set_op(3'd1, 3'd2, 2'b00, 4'b1111, 1'b0, 6'd0);
      exp_alu("dec_other", 32'd12, 1'b0, 3'b000);
      set_op(3'd1, 3'd2, 2'b11, 4'b0011, 1'b0, 6'd0);
      exp_alu("dec_11", 32'd12, 1'b0, 3'b000);

      // Immediate path
      write_reg(3'd1, 32'd10);
      set_op(3'd1, 3'd2, 2'b10, 4'b0000, 1'b1, 6'b111110);
      exp_alu("imm_neg2", 32'd8, 1'b0, 3'b000);
      set_op(3'd1, 3'd2, 2'b10, 4'b0000, 1'b0, 6'b111110);
      exp_alu("imm_off", 32'd17, 1'b0, 3'b000);

      // Edge operations
      write_reg(3'd4, 32'h8000_0000);
      write_reg(3'd5, 32'h1);
      write_reg(3'd6, 32'h21);
      write_reg(3'd7, 32'd31);
      write_reg(3'd3, 32'hFFFF_FFFF);
      set_op(3'd4, 3'd4, 2'b00, 4'b0010, 1'b0, 6'd0);
      exp_alu("add_wrap", 32'h0, 1'b1, 3'b000);
      set_op(3'd5, 3'd6, 2'b00, 4'b0101, 1'b0, 6'd0);
      exp_alu("sll_mask", 32'h2, 1'b0, 3'b011);
      set_op(3'd4, 3'd7, 2'b00, 4'b0110, 1'b0, 6'd0);
      exp_alu("srl_31", 32'h1, 1'b0, 3'b100);
      set_op(3'd4, 3'd7, 2'b00, 4'b0110, 1'b1, 6'b011111);
      exp_alu("srl_imm31", 32'h1, 1'b0, 3'b100);
      set_op(3'd3, 3'd5, 2'b00, 4'b1001, 1'b0, 6'd0);
      exp_alu("slt_unsigned", 32'h0, 1'b1, 3'b111);
      set_op(3'd0, 3'd5, 2'b00, 4'b0100, 1'b0, 6'd0);
      exp_alu("inv_0", 32'hFFFF_FFFF, 1'b0, 3'b010);
      set_op(3'd3, 3'd6, 2'b00, 4'b0111, 1'b0, 6'd0);
      exp_alu("and", 32'h21, 1'b0, 3'b101);
      set_op(3'd4, 3'd5, 2'b00, 4'b1000, 1'b0, 6'd0);
      exp_alu("or", 32'h8000_0001, 1'b0, 3'b110);

      // GPR0 behaviour
      write_reg(3'd0, 32'hFF);
      set_op(3'd0, 3'd0, 2'b00, 4'b0010, 1'b0, 6'd0);
`ifdef GPR_R0_ZERO_EN
      exp_rd("r0_write", 32'h0, 32'h0);
`else
      exp_rd("r0_write", 32'hFF, 32'hFF);
`endif

      // Asynchronous reset mid-cycle, write blocked during reset
      write_reg(3'd3, 32'h1234_5678);
      set_op(3'd3, 3'd3, 2'b00, 4'b0010, 1'b0, 6'd0);
      exp_rd("preload", 32'h1234_5678, 32'h1234_5678);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      exp_rd("async_clear", 32'h0, 32'h0);
      bus.reg_write      = 1'b1;
      bus.reg_write_dest = 3'd3;
      bus.reg_write_data = 32'hDEAD_BEEF;
      repeat (2) @(posedge clk);
      #1;
      exp_rd("write_in_reset", 32'h0, 32'h0);
      @(negedge clk);
      bus.reg_write = 1'b0;
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      set_op(3'd3, 3'd1, 2'b00, 4'b0010, 1'b0, 6'd0);
      exp_rd("after_reset", 32'h0, 32'h0);

      for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
      if (sb.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL drain actual=%0d required=0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/exec_regalu_core.md
Name: exec_regalu_core

Overview:
- Execute-stage core of the 32-bit single-cycle RISC datapath.
- Combines three functions:
  - 8-entry general-purpose register file (GPR): 2 combinational read ports, 1 synchronous write port.
  - ALU-control decoder: maps aluop and the instruction opcode to a 3-bit ALU select.
  - 32-bit ALU with zero flag.
- Sits between instruction decode (register address and immediate fields) and data memory / write-back.

Parameters:
- DATA_W, 32, register and ALU datapath width.
- REG_AW, 3, register address width (2**REG_AW registers).
- IMM_W, 6, width of the instruction immediate field, sign-extended to DATA_W.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- reg_write  input  1  GPR write enable.
- reg_write_dest  input  REG_AW  GPR write address.
- reg_write_data  input  DATA_W  GPR write data (from write-back mux).
- reg_read_addr1  input  REG_AW  read port 1 address (instr[11:9]).
- reg_read_addr2  input  REG_AW  read port 2 address (instr[8:6]).
- reg_read_data1  output  DATA_W  read port 1 data; drives ALU operand A.
- reg_read_data2  output  DATA_W  read port 2 data; also the store data.
- aluop  input  2  ALU operation class from the control unit.
- opcode  input  4  instruction opcode (instr[31:28]).
- alu_src  input  1  1 = operand B is the sign-extended immediate; 0 = reg_read_data2.
- imm  input  IMM_W  immediate field (instr[5:0]).
- alu_ctrl  output  3  decoded ALU select (debug/observability).
- alu_out  output  DATA_W  ALU result.
- zero  output  1  1 when alu_out == 0.

Behaviour:
- Reset:
  - rst_n low clears all 8 GPRs to 0 immediately, independent of clk.
  - Outputs are combinational, so after reset reg_read_data* = 0.
  - Write is blocked while rst_n is low.
  - Reset deasserting coincident with a clk edge: that edge performs no write.
- GPR write: on posedge clk, if reg_write = 1, GPR[reg_write_dest] <= reg_write_data. No write when reg_write = 0.
- GPR read: combinational, zero latency. No write-to-read bypass: data written at edge N is visible on the read ports after edge N. Both ports may read the same register.
- Operand B = alu_src ? sign-extended imm : reg_read_data2. Sign extension replicates imm[IMM_W-1].
- alucontrol, combinational:
  - aluop = 2'b10 (load/store): ADD.
  - aluop = 2'b01 (branch): SUB.
  - aluop = 2'b00 (R-type), by opcode:
    - 0010 ADD, 0011 SUB, 0100 INV, 0101 SLL, 0110 SRL, 0111 AND, 1000 OR, 1001 SLT.
    - Any other opcode: ADD.
  - aluop = 2'b11: ADD.
- ALU select encoding, combinational:
  - 000 ADD: a+b, modulo 2**DATA_W, carry dropped.
  - 001 SUB: a-b, modulo 2**DATA_W.
  - 010 INV: ~a (b ignored).
  - 011 SLL: a << b[4:0].
  - 100 SRL: a >> b[4:0], logical, zero fill.
  - 101 AND: a & b.
  - 110 OR: a | b.
  - 111 SLT: 1 if a < b unsigned, else 0.
  - Shift amount uses only the low log2(DATA_W) bits of b; upper bits are ignored.
- zero = (alu_out == 0), combinational, valid for every operation.
- No pipeline registers in the ALU path; the result settles in the same cycle as its inputs.

Optional Feature:
- Macro GPR_R0_ZERO_EN.
- Defined:
  - GPR[0] is hardwired to 0; writes to address 0 are discarded.
  - Reads of address 0 always return 0.
- Undefined (default): GPR[0] is an ordinary writable register, identical to the others.

Test Plan:
- Reset: preload GPR3 = 0x12345678, pulse rst_n low mid-cycle -> read of addr 3 returns 0 at once, before any clk edge; write with reg_write = 1 during reset -> ignored.
- Write/read: write GPR1 = 5, GPR2 = 7 -> visible on both ports after the edge. aluop = 00, opcode = 0010 -> alu_out = 12, zero = 0. opcode = 0011 with a = b = 7 -> alu_out = 0, zero = 1.
- Decode: aluop = 10 -> alu_ctrl = 000; aluop = 01 -> 001; aluop = 00 with opcode 1001 -> 111; opcode 1111 -> 000.
- Immediate path: GPR1 = 10, alu_src = 1, imm = 6'b111110 (-2), aluop = 10 -> alu_out = 8. With alu_src = 0, operand B = reg_read_data2.
- Edge ops: a = 0x80000000, b = 0x80000000, ADD -> 0, zero = 1. SLL a = 1, b = 0x21 -> 2 (amount 1). SRL a = 0x80000000, b = 31 -> 1. SLT a = 0xFFFFFFFF, b = 1 -> 0. INV a = 0 -> 0xFFFFFFFF.
- GPR_R0_ZERO_EN: write 0xFF to addr 0 -> reads 0 when defined, 0xFF when undefined.
